// File: rtl/demultiplexer_1to2_seq.sv
// Rebuilds a 2-bit word from a tagged serial stream: tag 0 = bit 0, then tag 1 = bit 1; out-of-order tags set sticky seq_err.
// One-cycle latency from the bit-1 transfer to out_valid; in_ready follows out_ready while a word is held.
module demultiplexer_1to2_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_data,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seq_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {WAIT0, WAIT1, FULL} state_t;

  state_t state;
  logic   bit0;
  logic   xfer;

  assign in_ready = (state == FULL) ? out_ready : 1'b1;
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT0;
      bit0        <= 1'b0;
      out         <= 2'b00;
      out_valid   <= 1'b0;
      seq_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      // Error sets below are written later so they win over a same-cycle clear.
      if (err_clr)
        seq_err <= 1'b0;
      case (state)
        WAIT0: begin
          if (xfer) begin
            if (!select) begin
              bit0  <= in_data;
              state <= WAIT1;
            end else begin
              seq_err <= 1'b1;
            end
          end
        end
        WAIT1: begin
          if (xfer) begin
            if (select) begin
              out         <= {in_data, bit0};
              out_valid   <= 1'b1;
              frame_count <= frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
              state       <= FULL;
            end else begin
              seq_err <= 1'b1;
              bit0    <= in_data;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= WAIT0;
            // The slot frees this cycle, so a tag-0 bit arriving now is not lost.
            if (xfer) begin
              if (!select) begin
                bit0  <= in_data;
                state <= WAIT1;
              end else begin
                seq_err <= 1'b1;
              end
            end
          end
        end
        default: state <= WAIT0;
      endcase
    end
  end

endmodule

// File: doc/demultiplexer_1to2_seq.md
DEMULTIPLEXER_1TO2_SEQ -- requirements
Module: demultiplexer_1to2_seq

Interface
REQ-001 Parameter CNT_W, default 8, width of the completed-word counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 in_data  input  1  serial bit from the 2:1 mux output stream.
REQ-005 select  input  1  channel tag of in_data (0 = bit 0, 1 = bit 1).
REQ-006 in_valid  input  1  in_data/select are meaningful this cycle.
REQ-007 in_ready  output  1  block accepts a bit this cycle; a transfer occurs when in_valid & in_ready.
REQ-008 out  output  2  reassembled word {bit1, bit0}, registered.
REQ-009 out_valid  output  1  out holds an unconsumed word.
REQ-010 out_ready  input  1  consumer takes the word; a transfer occurs when out_valid & out_ready.
REQ-011 seq_err  output  1  sticky flag: a tag arrived out of order.
REQ-012 err_clr  input  1  synchronous clear of seq_err.
REQ-013 frame_count  output  CNT_W  count of completed words, modulo 2^CNT_W.

Function
REQ-014 The FSM SHALL have three states: WAIT0 (expect tag 0), WAIT1 (expect tag 1), FULL (word held for the consumer).
REQ-015 in_ready SHALL be combinational: 1 in WAIT0 and WAIT1; equal to out_ready in FULL.
REQ-016 WAIT0, transfer with select=0: stage in_data as bit 0; next state WAIT1.
REQ-017 WAIT0, transfer with select=1: discard the bit, set seq_err; stay in WAIT0.
REQ-018 WAIT1, transfer with select=1: load out <= {in_data, staged bit 0}, set out_valid, increment frame_count; next state FULL. out_valid rises on the edge after the bit-1 transfer (1-cycle latency).
REQ-019 WAIT1, transfer with select=0: set seq_err, replace the staged bit 0 with the new in_data; stay in WAIT1.
REQ-020 FULL, out_ready=0: hold out, out_valid=1, and the state; in_ready=0, so no input is consumed.
REQ-021 FULL, out_ready=1 with no input transfer: clear out_valid; next state WAIT0.
REQ-022 FULL, out_ready=1 with a select=0 transfer in the same cycle: clear out_valid, stage the new bit 0; next state WAIT1. No input cycle is lost.
REQ-023 FULL, out_ready=1 with a select=1 transfer in the same cycle: clear out_valid, set seq_err, discard the bit; next state WAIT0.
REQ-024 out SHALL keep its last value when out_valid=0; it changes only in REQ-018.
REQ-025 frame_count SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-026 seq_err, same cycle: a new error takes priority over err_clr, so seq_err stays 1.
REQ-027 Cycles with in_valid=0 SHALL leave all state unchanged, apart from the output handshake in REQ-021.

Reset
REQ-028 While reset=1, the block SHALL hold: state=WAIT0, out=2'b00, out_valid=0, seq_err=0, frame_count=0, staged bit=0. in_ready then reads 1.
REQ-029 Reset asserted mid-word (WAIT1) or mid-handshake (FULL) SHALL discard the partial or held word with no out_valid pulse.
REQ-030 After reset deasserts, the first accepted bit SHALL be treated as a tag-0 expectation (WAIT0).

Verification
REQ-031 Reset, then out_ready=1, send (select=0,in_data=1) then (select=1,in_data=0) -> out=2'b01 with out_valid=1 for exactly one cycle, on the edge after the second transfer; frame_count=1.
REQ-032 out_ready=0, complete the word 2'b10 -> out_valid stays 1 and in_ready=0 while a pending (select=0) is held off. Raise out_ready -> that bit is accepted in the same cycle; state WAIT1, frame_count=1.
REQ-033 In WAIT0 send select=1 -> seq_err=1, out_valid stays 0. Pulse err_clr -> seq_err=0. Pulse err_clr in the same cycle as a new error -> seq_err=1.
REQ-034 Send tags 0(1), 0(0), 1(1) -> seq_err=1, out=2'b10, showing the second bit 0 replaced the first.
REQ-035 CNT_W=2, complete 5 words with out_ready=1 -> frame_count sequence 1,2,3,0,1.
REQ-036 Assert reset asynchronously between clock edges while in FULL -> out_valid=0, out=2'b00, frame_count=0 immediately, with no clock edge needed.
